// File: rtl/pir_pkg.sv
// Shared definitions for the PIR sensor front end: channel count, level width,
// the controller's alarm threshold and the one-hot sequencer state encoding.
package pir_pkg;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned LEVEL_W   = 7;
    localparam int unsigned THRESHOLD = 50;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_REQ     = 4'b0010,
        ST_NEXT    = 4'b0100,
        ST_PUBLISH = 4'b1000
    } pir_state_e;

    function automatic logic [LEVEL_W-1:0] level_max(input logic [LEVEL_W-1:0] a,
                                                     input logic [LEVEL_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pir_adc_handshake.sv
// ADC request/acknowledge engine: raises adc_req on start, holds the channel
// select stable, and reports completion either by ack (data valid) or by
// timeout after ACK_TIMEOUT request cycles. An ack on the final cycle wins.
module pir_adc_handshake
    import pir_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 63
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         ch_i,
    input  logic               adc_ack_i,
    input  logic [LEVEL_W-1:0] adc_data_i,
    output logic               adc_req_o,
    output logic [1:0]         adc_ch_o,
    output logic               done_o,
    output logic               acked_o,
    output logic               timeout_o,
    output logic [LEVEL_W-1:0] sample_o
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);

    logic             req_q;
    logic [1:0]       ch_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_last;

    // Completion decode; ack takes precedence over a coincident timeout
    always_comb begin
        tmo_last  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
        acked_o   = req_q & adc_ack_i;
        timeout_o = req_q & ~adc_ack_i & tmo_last;
        done_o    = acked_o | timeout_o;
        sample_o  = adc_data_i;
    end

    // Request register, held channel select and timeout counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= 1'b0;
            ch_q  <= '0;
            tmo_q <= '0;
        end else if (abort_i) begin
            req_q <= 1'b0;
            tmo_q <= '0;
        end else if (start_i) begin
            req_q <= 1'b1;
            ch_q  <= ch_i;
            tmo_q <= '0;
        end else if (req_q) begin
            if (done_o) begin
                req_q <= 1'b0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign adc_req_o = req_q;
    assign adc_ch_o  = ch_q;

endmodule

// File: rtl/pir_sensor_frontend.sv
// PIR sensor front end: round-robin scan of three PIR channels through one
// shared ADC, per-channel block averaging of 2^AVG_LOG2 scans and publication
// of the three levels with a single level_valid strobe.
// Build option PIR_PEAK_HOLD_EN: track the per-window peak instead of the sum.
module pir_sensor_frontend
    import pir_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned ACK_TIMEOUT   = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                adc_req,
    output logic [1:0]          adc_ch,
    input  logic                adc_ack,
    input  logic [LEVEL_W-1:0]  adc_data,
    output logic [LEVEL_W-1:0]  pir_sensor_1,
    output logic [LEVEL_W-1:0]  pir_sensor_2,
    output logic [LEVEL_W-1:0]  pir_sensor_3,
    output logic                level_valid,
    output logic                adc_fault
);

    localparam int unsigned PCNT_W    = $clog2(SAMPLE_PERIOD);
    localparam int unsigned SCNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SCNT_LAST = (1 << AVG_LOG2) - 1;
`ifdef PIR_PEAK_HOLD_EN
    localparam int unsigned ACC_W     = LEVEL_W;
`else
    localparam int unsigned ACC_W     = LEVEL_W + AVG_LOG2;
`endif

    pir_state_e          state_q;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic [1:0]          ch_q;
    logic [ACC_W-1:0]    acc_q   [NUM_CH];
    logic [LEVEL_W-1:0]  level_q [NUM_CH];
    logic                level_valid_q;
    logic                fault_q;

    logic                scan_start;
    logic                hs_start;
    logic [1:0]          hs_ch;
    logic                hs_done;
    logic                hs_acked;
    logic                hs_timeout;
    logic [LEVEL_W-1:0]  hs_sample;
    logic [LEVEL_W-1:0]  smp;
    logic [ACC_W-1:0]    acc_upd;

    // Scan period counter; held at zero while scanning is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (!enable || (pcnt_q == PCNT_W'(SAMPLE_PERIOD - 1))) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    // Request launch: first channel on scan start, next channel after the gap cycle
    always_comb begin
        scan_start = enable & (pcnt_q == PCNT_W'(SAMPLE_PERIOD - 1));
        hs_start   = 1'b0;
        hs_ch      = '0;
        if (enable) begin
            if (state_q == ST_IDLE && scan_start) begin
                hs_start = 1'b1;
                hs_ch    = 2'd0;
            end else if (state_q == ST_NEXT && ch_q != 2'd2) begin
                hs_start = 1'b1;
                hs_ch    = ch_q + 2'd1;
            end
        end
    end

    // A timed-out conversion contributes the channel's last published level
    always_comb begin
        smp = hs_acked ? hs_sample : level_q[ch_q];
`ifdef PIR_PEAK_HOLD_EN
        acc_upd = level_max(acc_q[ch_q], smp);
`else
        acc_upd = acc_q[ch_q] + ACC_W'(smp);
`endif
    end

    pir_adc_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_hs (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (hs_start),
        .abort_i    (~enable),
        .ch_i       (hs_ch),
        .adc_ack_i  (adc_ack),
        .adc_data_i (adc_data),
        .adc_req_o  (adc_req),
        .adc_ch_o   (adc_ch),
        .done_o     (hs_done),
        .acked_o    (hs_acked),
        .timeout_o  (hs_timeout),
        .sample_o   (hs_sample)
    );

    // Scan sequencer: accumulation, window counting, publication and fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            scnt_q        <= '0;
            level_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i]   <= '0;
                level_q[i] <= '0;
            end
        end else begin
            level_valid_q <= 1'b0;
            if (!enable) begin
                // Abandon the partial window; published levels are kept
                state_q <= ST_IDLE;
                ch_q    <= '0;
                scnt_q  <= '0;
                fault_q <= 1'b0;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (scan_start) begin
                            ch_q    <= '0;
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (hs_done) begin
                            acc_q[ch_q] <= acc_upd;
                            if (hs_timeout) begin
                                fault_q <= 1'b1;
                            end
                            state_q <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (ch_q != 2'd2) begin
                            ch_q    <= ch_q + 2'd1;
                            state_q <= ST_REQ;
                        end else if (scnt_q == SCNT_W'(SCNT_LAST)) begin
                            scnt_q  <= '0;
                            state_q <= ST_PUBLISH;
                        end else begin
                            scnt_q  <= scnt_q + 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PUBLISH: begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef PIR_PEAK_HOLD_EN
                            level_q[i] <= acc_q[i];
`else
                            level_q[i] <= LEVEL_W'(acc_q[i] >> AVG_LOG2);
`endif
                            acc_q[i] <= '0;
                        end
                        level_valid_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pir_sensor_1 = level_q[0];
    assign pir_sensor_2 = level_q[1];
    assign pir_sensor_3 = level_q[2];
    assign level_valid  = level_valid_q;
    assign adc_fault    = fault_q;

endmodule

// File: tb/tb_pir_sensor_frontend.sv
// Scoreboard bench for pir_sensor_frontend: an ADC model serves per-channel
// sample queues, stimulus pushes expected published levels, and a monitor
// checks them whenever level_valid pulses.
module tb_pir_sensor_frontend;

    localparam int unsigned SP = 16;
    localparam int unsigned AL = 2;
    localparam int unsigned TO = 63;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       adc_req;
    logic [1:0] adc_ch;
    logic       adc_ack = 1'b0;
    logic [6:0] adc_data = '0;
    logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
    logic       level_valid;
    logic       adc_fault;

    always #5 clk = ~clk;

    pir_sensor_frontend #(
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (AL),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .adc_req      (adc_req),
        .adc_ch       (adc_ch),
        .adc_ack      (adc_ack),
        .adc_data     (adc_data),
        .pir_sensor_1 (pir_sensor_1),
        .pir_sensor_2 (pir_sensor_2),
        .pir_sensor_3 (pir_sensor_3),
        .level_valid  (level_valid),
        .adc_fault    (adc_fault)
    );

    int          vecs = 0;
    int          errs = 0;
    logic [20:0] exp_q[$];
    int          sq[3][$];
    int          ack_dly[3];
    int          noack_ch = -1;
    bit          spur = 1'b0;
    int          wcnt = 0;
    int          last_run[3];
    int          run_len = 0;
    logic [1:0]  run_ch = '0;
    bit          ch_moved = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_lv = 1'b0;
    int          scan_cnt = 0;
    int          lvl_exp[3];

    task automatic chk(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int calc(input int a, input int b, input int c, input int d);
`ifdef PIR_PEAK_HOLD_EN
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
`else
        return (a + b + c + d) >> AL;
`endif
    endfunction

    // ADC model: acks after ack_dly request cycles, optional spurious acks when idle
    always @(negedge clk) begin
        adc_ack = 1'b0;
        if (adc_req) begin
            wcnt++;
            if (int'(adc_ch) != noack_ch && wcnt == ack_dly[adc_ch]) begin
                adc_ack  = 1'b1;
                adc_data = (sq[adc_ch].size() != 0) ? 7'(sq[adc_ch].pop_front()) : 7'd0;
            end
        end else begin
            wcnt = 0;
            if (spur) begin
                adc_ack  = 1'b1;
                adc_data = 7'd127;
            end
        end
    end

    // Monitor: request run lengths, channel stability, publication scoreboard
    always @(negedge clk) begin
        logic [20:0] e;
        if (adc_req) begin
            if (!prev_req) begin
                run_len  = 0;
                run_ch   = adc_ch;
                ch_moved = 1'b0;
                if (adc_ch == 2'd0) scan_cnt++;
            end else if (adc_ch != run_ch) begin
                ch_moved = 1'b1;
            end
            run_len++;
        end else if (prev_req) begin
            last_run[run_ch] = run_len;
            chk("adc_ch_stable_during_req", int'(ch_moved), 0);
        end
        if (level_valid) begin
            chk("level_valid_one_cycle", int'(prev_lv), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_publish", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pir_sensor_1", int'(pir_sensor_1), int'(e[20:14]));
                chk("pir_sensor_2", int'(pir_sensor_2), int'(e[13:7]));
                chk("pir_sensor_3", int'(pir_sensor_3), int'(e[6:0]));
            end
        end
        prev_req = adc_req;
        prev_lv  = level_valid;
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_publish_seen"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // One averaging window: queue 4 scans of samples and the expected levels
    task automatic window(input string name,
                          input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3,
                          input int c0, input int c1, input int c2, input int c3);
        int v[3][4];
        int e[3];
        v[0][0] = a0; v[0][1] = a1; v[0][2] = a2; v[0][3] = a3;
        v[1][0] = b0; v[1][1] = b1; v[1][2] = b2; v[1][3] = b3;
        v[2][0] = c0; v[2][1] = c1; v[2][2] = c2; v[2][3] = c3;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (c == noack_ch) v[c][k] = lvl_exp[c];
                else sq[c].push_back(v[c][k]);
            end
            e[c] = calc(v[c][0], v[c][1], v[c][2], v[c][3]);
        end
        exp_q.push_back({7'(e[0]), 7'(e[1]), 7'(e[2])});
        for (int c = 0; c < 3; c++) lvl_exp[c] = e[c];
        drain(name, 3000);
    endtask

    initial begin
        int n;
        for (int c = 0; c < 3; c++) begin
            ack_dly[c]  = 3;
            lvl_exp[c]  = 0;
            last_run[c] = 0;
        end

        repeat (3) @(negedge clk);
        chk("reset_adc_req", int'(adc_req), 0);
        chk("reset_adc_ch", int'(adc_ch), 0);
        chk("reset_pir1", int'(pir_sensor_1), 0);
        chk("reset_pir2", int'(pir_sensor_2), 0);
        chk("reset_pir3", int'(pir_sensor_3), 0);
        chk("reset_level_valid", int'(level_valid), 0);
        chk("reset_adc_fault", int'(adc_fault), 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Constant levels, spurious acks outside REQ must be ignored
        spur = 1'b1;
        window("const", 60, 60, 60, 60, 10, 10, 10, 10, 50, 50, 50, 50);
        spur = 1'b0;
        chk("const_fault", int'(adc_fault), 0);

        // Truncating average: 101>>2 = 25, 6>>2 = 1, 401>>2 = 100
        window("trunc", 10, 20, 30, 41, 0, 1, 2, 3, 100, 100, 100, 101);

        // Ack coincident with the last timeout cycle counts as a real ack
        ack_dly[2] = int'(TO);
        window("ack_at_timeout", 1, 1, 1, 1, 4, 4, 4, 4, 127, 127, 127, 127);
        ack_dly[2] = 3;
        chk("ack_at_timeout_fault", int'(adc_fault), 0);
        chk("ack_at_timeout_req_len", last_run[2], int'(TO));

        // ch1 never acks: hold-last level, sticky fault, ch2 still sampled
        noack_ch = 1;
        window("timeout", 8, 8, 8, 8, 0, 0, 0, 0, 20, 21, 22, 23);
        noack_ch = -1;
        chk("timeout_fault", int'(adc_fault), 1);
        chk("timeout_req_len", last_run[1], int'(TO));

        // Drop enable during the ch2 request
        for (int c = 0; c < 3; c++) sq[c].push_back(9);
        n = 0;
        @(negedge clk);
        while (!(adc_req && adc_ch == 2'd2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drop_reached_ch2_req", int'(adc_req && adc_ch == 2'd2), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_adc_req", int'(adc_req), 0);
        chk("drop_adc_fault", int'(adc_fault), 0);
        repeat (5) @(negedge clk);
        chk("drop_hold_pir1", int'(pir_sensor_1), lvl_exp[0]);
        chk("drop_hold_pir2", int'(pir_sensor_2), lvl_exp[1]);
        chk("drop_hold_pir3", int'(pir_sensor_3), lvl_exp[2]);
        for (int c = 0; c < 3; c++) sq[c].delete();
        enable   = 1'b1;
        scan_cnt = 0;
        window("reenable", 33, 33, 33, 33, 44, 44, 44, 44, 55, 55, 55, 55);
        chk("reenable_scans_to_publish", scan_cnt, 4);

        // Peak-hold windows (averaged in the default build: 147>>2 = 36, then 3)
        window("peak", 7, 7, 7, 7, 7, 7, 7, 7, 5, 90, 12, 40);
        window("peak_reset", 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vecs);
        $fatal(1, "time limit reached");
    end

endmodule
